// File: rtl/instr_type_decode_stage.sv
// Decode stage: classifies fetched instructions into a one-hot type code and
// buffers them with PC through a two-entry skid buffer with valid/ready on both sides.
module instr_type_decode_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9:0]      out_code,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam int unsigned CODE_W = 10;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              illegal;
    logic [ILEN-1:0]   instr;
    logic [XLEN-1:0]   pc;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;
  entry_t head, skid, dec_entry;
  logic   accept, pop;
  logic   load_head, load_skid, head_from_skid;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Opcode classification on the input side
  always_comb begin
    dec_entry.code    = '0;
    dec_entry.illegal = 1'b0;
    dec_entry.instr   = in_instr;
    dec_entry.pc      = in_pc;
    case (in_instr[6:0])
      7'b1101111:                         dec_entry.code = 10'b00_0000_0001;
      7'b1100111:                         dec_entry.code = 10'b00_0000_0010;
      7'b0110111:                         dec_entry.code = 10'b00_0000_0100;
      7'b0010111:                         dec_entry.code = 10'b00_0000_1000;
      7'b1100011:                         dec_entry.code = 10'b00_0001_0000;
      7'b0110011, 7'b0111011, 7'b1010011: dec_entry.code = 10'b00_0010_0000;
      7'b0100011, 7'b0100111:             dec_entry.code = 10'b00_0100_0000;
      7'b0010011, 7'b0011011:             dec_entry.code = 10'b00_1000_0000;
      7'b0000011, 7'b0000111:             dec_entry.code = 10'b01_0000_0000;
      7'b1110011:                         dec_entry.code = 10'b10_0000_0000;
      default:                            dec_entry.illegal = 1'b1;
    endcase
  end

  // Next-state and buffer steering; flush overrides everything
  always_comb begin
    state_next     = state;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_head  = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_head = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next     = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next     = EMPTY;
      load_head      = 1'b0;
      load_skid      = 1'b0;
      head_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Handshake flags are registered from next state so in_ready never sees out_ready combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      head      <= '0;
      skid      <= '0;
    end else begin
      in_ready  <= (state_next != FULL);
      out_valid <= (state_next != EMPTY);
      if (load_head) begin
        head <= dec_entry;
      end else if (head_from_skid) begin
        head <= skid;
      end
      if (load_skid) begin
        skid <= dec_entry;
      end
    end
  end

  assign out_code    = head.code;
  assign out_illegal = head.illegal;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;

endmodule

// File: tb/tb_instr_type_decode_stage.sv
// Directed bench for instr_type_decode_stage: decode map, skid buffering, flush and reset.
module tb_instr_type_decode_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_code;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_illegal;

  int vectors;
  int miscompares;

  instr_type_decode_stage #(.XLEN(64), .ILEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_instr(out_instr), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  logic [6:0] ops  [15];
  logic [9:0] codes[15];

  initial begin
    vectors = 0;
    miscompares = 0;
    ops = '{7'h6F, 7'h67, 7'h37, 7'h17, 7'h63, 7'h33, 7'h3B, 7'h53,
            7'h23, 7'h27, 7'h13, 7'h1B, 7'h03, 7'h07, 7'h73};
    codes = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h020, 10'h020,
              10'h040, 10'h040, 10'h080, 10'h080, 10'h100, 10'h100, 10'h200};
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_code", 64'(out_code), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    reset = 1'b0;

    // Legal opcodes back to back
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 32'(i) << 12 | 32'(ops[i]), 64'h1000 + 64'(i) * 64'd4);
      @(negedge clk);
      chk($sformatf("op%02h_code", ops[i]), 64'(out_code), 64'(codes[i]));
      chk($sformatf("op%02h_illegal", ops[i]), 64'(out_illegal), 64'd0);
      chk($sformatf("op%02h_instr", ops[i]), 64'(out_instr), 64'(32'(i) << 12 | 32'(ops[i])));
    end

    // Illegal opcodes
    drive(1'b1, 32'h0000007F, 64'h2000);
    @(negedge clk);
    chk("ill7f_valid", 64'(out_valid), 64'd1);
    chk("ill7f_code", 64'(out_code), 64'd0);
    chk("ill7f_illegal", 64'(out_illegal), 64'd1);
    drive(1'b1, 32'h00000000, 64'h2004);
    @(negedge clk);
    chk("ill00_valid", 64'(out_valid), 64'd1);
    chk("ill00_code", 64'(out_code), 64'd0);
    chk("ill00_illegal", 64'(out_illegal), 64'd1);
    drive(1'b0, 32'h0, 64'h0);
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Eight back-to-back with out_ready high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h00000013, 64'(i) * 64'd4);
      @(negedge clk);
      chk($sformatf("b2b%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("b2b%0d_pc", i), out_pc, 64'(i) * 64'd4);
    end
    drive(1'b0, 32'h0, 64'h0);
    @(negedge clk);
    chk("b2b_end_valid", 64'(out_valid), 64'd0);

    // Stall: fill both entries, blocked third input, then release
    out_ready = 1'b0;
    drive(1'b1, 32'h00000033, 64'h100);
    @(negedge clk);
    chk("st1_in_ready", 64'(in_ready), 64'd1);
    chk("st1_pc", out_pc, 64'h100);
    drive(1'b1, 32'h00000063, 64'h104);
    @(negedge clk);
    chk("st2_in_ready", 64'(in_ready), 64'd0);
    chk("st2_pc", out_pc, 64'h100);
    drive(1'b1, 32'h00000013, 64'h108);
    @(negedge clk);
    chk("st3_hold_pc", out_pc, 64'h100);
    chk("st3_hold_code", 64'(out_code), 64'h020);
    chk("st3_in_ready", 64'(in_ready), 64'd0);
    drive(1'b0, 32'h0, 64'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel1_valid", 64'(out_valid), 64'd1);
    chk("rel1_pc", out_pc, 64'h104);
    chk("rel1_code", 64'(out_code), 64'h010);
    chk("rel1_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("rel2_valid", 64'(out_valid), 64'd0);
    chk("rel2_last_pc", out_pc, 64'h104);

    // Flush while FULL with input presented
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 64'h200);
    @(negedge clk);
    drive(1'b1, 32'h00000013, 64'h204);
    @(negedge clk);
    chk("fl_full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00000013, 64'h208);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    chk("fl_full_valid", 64'(out_valid), 64'd0);
    chk("fl_full_in_ready2", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_full_after_valid", 64'(out_valid), 64'd0);

    // Flush in ONE while an input is acceptable: input dropped
    drive(1'b1, 32'h00000013, 64'h300);
    out_ready = 1'b0;
    @(negedge clk);
    chk("fl_one_pc", out_pc, 64'h300);
    flush = 1'b1;
    drive(1'b1, 32'h00000013, 64'h304);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    chk("fl_one_valid", 64'(out_valid), 64'd0);
    chk("fl_one_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_one_after_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream, between edges
    drive(1'b1, 32'h00000073, 64'h400);
    @(negedge clk);
    chk("ar_pre_pc", out_pc, 64'h400);
    drive(1'b1, 32'h00000073, 64'h404);
    out_ready = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    drive(1'b0, 32'h0, 64'h0);
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_code", 64'(out_code), 64'd0);
    chk("ar_pc", out_pc, 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ar_post_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h00000017, 64'h500);
    @(negedge clk);
    chk("ar_resume_valid", 64'(out_valid), 64'd1);
    chk("ar_resume_pc", out_pc, 64'h500);
    chk("ar_resume_code", 64'(out_code), 64'h008);
    drive(1'b0, 32'h0, 64'h0);
    @(negedge clk);
    chk("ar_resume_drain", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
